// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: fetch (F) vs loader (L), boot lockout, bounded L starvation; IMEM_WRITE_LOCK_EN locks RUN writes.
// Latency: grant is combinational, read data/rvalid one cycle after the grant, writes land at the grant edge.
// Backpressure: a denied requester holds its request; in RUN, L is forced through after STARVE_MAX denied cycles.
module imem_port_arbiter #(
    parameter int DEPTH_LOG2    = 10,
    parameter int STARVE_MAX    = 4,
    parameter int BOOT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req,
    input  logic [31:0]           f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [31:0]           f_rdata,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [31:0]           l_addr,
    input  logic [31:0]           l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [31:0]           l_rdata,
    input  logic                  boot_done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  boot_mode,
    output logic                  wr_err
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_L    = 2'd2
    } owner_t;

    localparam state_t RST_STATE = (BOOT_ON_RESET != 0) ? ST_BOOT : ST_RUN;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     f_rdata_q, l_rdata_q;
    logic            lock_hit;
    logic            unused_addr;

    assign unused_addr = ^{f_addr[31:DEPTH_LOG2+2], f_addr[1:0],
                           l_addr[31:DEPTH_LOG2+2], l_addr[1:0]};

    // Grant decision; reset forces every grant low so memory sees no access.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (state_q == ST_BOOT) begin
                l_gnt = l_req;
            end else begin
                l_gnt = l_req & (~f_req | (starve_q == STARVE_LIM));
                f_gnt = f_req & ~l_gnt;
            end
        end
    end

`ifdef IMEM_WRITE_LOCK_EN
    logic wr_err_q, wr_err_d;

    assign lock_hit = l_gnt & l_we & (state_q == ST_RUN);
    assign wr_err_d = wr_err_q | lock_hit;
    assign wr_err   = wr_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end
`else
    assign lock_hit = 1'b0;
    assign wr_err   = 1'b0;
`endif

    always_comb begin
        mem_en    = (f_gnt | l_gnt) & ~lock_hit;
        mem_we    = l_gnt & l_we & ~lock_hit;
        mem_wdata = l_wdata;
        mem_addr  = '0;
        if (l_gnt) begin
            mem_addr = l_addr[DEPTH_LOG2+1:2];
        end else if (f_gnt) begin
            mem_addr = f_addr[DEPTH_LOG2+1:2];
        end
    end

    // Read return: owner's port passes memory data through, the other holds.
    always_comb begin
        f_rvalid  = (owner_q == OWN_F);
        l_rvalid  = (owner_q == OWN_L);
        f_rdata   = f_rvalid ? mem_rdata : f_rdata_q;
        l_rdata   = l_rvalid ? mem_rdata : l_rdata_q;
        boot_mode = (state_q == ST_BOOT);
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = OWN_NONE;
        starve_d = '0;
        if (state_q == ST_BOOT && boot_done) begin
            state_d = ST_RUN;
        end
        if (f_gnt) begin
            owner_d = OWN_F;
        end else if (l_gnt && !l_we) begin
            owner_d = OWN_L;
        end
        if (l_req && !l_gnt) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_STATE;
            owner_q   <= OWN_NONE;
            starve_q  <= '0;
            f_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            f_rdata_q <= f_rdata;
            l_rdata_q <= l_rdata;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with an in-bench memory array and a transaction-level reference model.
module tb_imem_port_arbiter;

    localparam int DEPTH_LOG2 = 10;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, boot_done = 1'b0;
    logic [31:0]           f_addr = '0, l_addr = '0, l_wdata = '0;
    logic                  f_gnt, f_rvalid, l_gnt, l_rvalid;
    logic [31:0]           f_rdata, l_rdata;
    logic                  mem_en, mem_we, boot_mode, wr_err;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    imem_port_arbiter #(
        .DEPTH_LOG2(DEPTH_LOG2), .STARVE_MAX(STARVE_MAX), .BOOT_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .boot_done(boot_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .boot_mode(boot_mode), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'hA5A50000 ^ (i * 32'h01010101);
    endfunction

    // Memory array the DUT drives.
    logic [31:0] bmem [DEPTH];
    always @(posedge clk) begin
        if (mem_en && mem_we) bmem[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= bmem[mem_addr];
    end

    // Reference model: word-array contents, pending read, denied-cycle count.
    logic [31:0]           ref_mem [DEPTH];
    logic                  m_boot;
    int                    m_pend;
    logic [31:0]           m_pdata, m_last_f, m_last_l;
    int                    m_wait;
    logic                  m_err;
    logic                  exp_f_gnt, exp_l_gnt, exp_en, exp_we, exp_lock;
    logic [DEPTH_LOG2-1:0] exp_addr;

    function automatic void predict();
        logic [31:0] a;
        exp_f_gnt = 1'b0;
        exp_l_gnt = 1'b0;
        if (!rst) begin
            if (m_boot) begin
                exp_l_gnt = l_req;
            end else begin
                exp_l_gnt = l_req && (!f_req || m_wait >= STARVE_MAX);
                exp_f_gnt = f_req && !exp_l_gnt;
            end
        end
        exp_lock = 1'b0;
`ifdef IMEM_WRITE_LOCK_EN
        exp_lock = exp_l_gnt && l_we && !m_boot;
`endif
        exp_en   = (exp_f_gnt || exp_l_gnt) && !exp_lock;
        exp_we   = exp_l_gnt && l_we && !exp_lock;
        a        = exp_l_gnt ? l_addr : f_addr;
        exp_addr = a[DEPTH_LOG2+1:2];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bmem[i]    = init_val(i);
            ref_mem[i] = init_val(i);
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_boot = 1'b1; m_pend = 0; m_wait = 0; m_err = 1'b0;
                m_pdata = '0; m_last_f = '0; m_last_l = '0;
            end else begin
                predict();
                if (m_pend == 1) m_last_f = m_pdata;
                if (m_pend == 2) m_last_l = m_pdata;
                m_pend = 0;
                if (exp_we) ref_mem[exp_addr] = l_wdata;
                if (exp_f_gnt) begin
                    m_pend = 1; m_pdata = ref_mem[exp_addr];
                end else if (exp_l_gnt && !l_we) begin
                    m_pend = 2; m_pdata = ref_mem[exp_addr];
                end
                if (l_req && !exp_l_gnt) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
                else m_wait = 0;
                if (exp_lock) m_err = 1'b1;
                if (m_boot && boot_done) m_boot = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            predict();
            chk("f_gnt", 32'(f_gnt), 32'(exp_f_gnt));
            chk("l_gnt", 32'(l_gnt), 32'(exp_l_gnt));
            chk("mem_en", 32'(mem_en), 32'(exp_en));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_en) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("f_rvalid", 32'(f_rvalid), 32'(m_pend == 1));
            chk("l_rvalid", 32'(l_rvalid), 32'(m_pend == 2));
            chk("f_rdata", f_rdata, (m_pend == 1) ? m_pdata : m_last_f);
            chk("l_rdata", l_rdata, (m_pend == 2) ? m_pdata : m_last_l);
            chk("boot_mode", 32'(boot_mode), 32'(m_boot));
            chk("wr_err", 32'(wr_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] prog [4];
    logic        lock_on;

    initial begin
        prog[0] = 32'h00500293; prog[1] = 32'h00300313;
        prog[2] = 32'h006283B3; prog[3] = 32'h00002403;
`ifdef IMEM_WRITE_LOCK_EN
        lock_on = 1'b1;
`else
        lock_on = 1'b0;
`endif
        tick(); tick();
        #1;
        chk("rst boot_mode", 32'(boot_mode), 32'd1);
        chk("rst f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst f_rdata", f_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Boot: loader writes while fetch is stalled.
        f_req = 1'b1; f_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            l_req = 1'b1; l_we = 1'b1; l_addr = 32'(i * 4); l_wdata = prog[i];
            #1;
            chk("boot f_gnt", 32'(f_gnt), 32'd0);
            chk("boot mem_addr", 32'(mem_addr), 32'(i));
            chk("boot mem_we", 32'(mem_we), 32'd1);
            tick();
        end
        l_req = 1'b0; l_we = 1'b0; boot_done = 1'b1;
        #1;
        chk("boot_done f_gnt", 32'(f_gnt), 32'd0);
        tick();
        boot_done = 1'b0;
        #1;
        chk("run fetch gnt", 32'(f_gnt), 32'd1);
        chk("run fetch addr", 32'(mem_addr), 32'd2);
        tick();

        // Starvation: L read of 0x4 against continuous fetch.
        f_addr = 32'h0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4;
        #1;
        chk("fetch rvalid", 32'(f_rvalid), 32'd1);
        chk("fetch rdata", f_rdata, 32'h006283B3);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) #1;
            chk("starve l_gnt", 32'(l_gnt), 32'(c == 5));
            chk("starve f_gnt", 32'(f_gnt), 32'(c != 5));
            tick();
        end
        l_req = 1'b0;
        f_addr = 32'h1008;
        #1;
        chk("starve l_rvalid", 32'(l_rvalid), 32'd1);
        chk("starve l_rdata", l_rdata, 32'h00300313);
        chk("wrap mem_addr", 32'(mem_addr), 32'd2);
        tick();
        #1;
        chk("wrap rdata", f_rdata, 32'h006283B3);

        // Loader write in RUN, then fetch the same word.
        f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF;
        #1;
        chk("run wr l_gnt", 32'(l_gnt), 32'd1);
        chk("run wr mem_we", 32'(mem_we), 32'(!lock_on));
        tick();
        l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h10;
        tick();
        f_req = 1'b0;
        #1;
        chk("raw rdata", f_rdata, lock_on ? init_val(4) : 32'hDEADBEEF);
        chk("wr_err", 32'(wr_err), 32'(lock_on));
        tick(); tick();
        #1;
        chk("wr_err sticky", 32'(wr_err), 32'(lock_on));

        // Reset in the cycle after a fetch grant drops the read.
        f_req = 1'b1; f_addr = 32'h8;
        tick();
        rst = 1'b1; f_req = 1'b0;
        #1;
        chk("midrd boot_mode", 32'(boot_mode), 32'd1);
        chk("midrd f_rvalid", 32'(f_rvalid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        #1;
        chk("postrst f_rvalid", 32'(f_rvalid), 32'd0);

        // Mixed traffic: BOOT, release at k=20, late boot_done ignored in RUN.
        for (int k = 0; k < 60; k++) begin
            f_req     = (k % 3) != 0;
            f_addr    = 32'(k * 4) + 32'(k << 12);
            l_req     = (k % 5) < 3;
            l_we      = (k % 7) == 2;
            l_addr    = 32'((k * 12) & 8'hFC);
            l_wdata   = 32'(k) * 32'h11111111;
            boot_done = (k == 20) || (k == 45);
            tick();
        end
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; boot_done = 1'b0;
        tick(); tick();
        #1;
        chk("final boot_mode", 32'(boot_mode), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
